// File: rtl/sub_serial.sv
// Bit-serial subtractor: computes a - b one bit per clock (LSB first) with a ripple borrow.
// Optional `SUB_SERIAL_OVF_EN adds a registered signed-overflow flag (ovf).
module sub_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
`ifdef SUB_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             borrow;
  logic [CW-1:0]    count;

  logic diff;
  logic borrow_nxt;

  // One full-subtractor bit on the current LSBs of the shifting operands.
  assign diff       = a_reg[0] ^ b_reg[0] ^ borrow;
  assign borrow_nxt = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & borrow);

  assign busy = (state == SUB);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      out        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      borrow     <= 1'b0;
      count      <= '0;
      borrow_out <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
      ovf        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            a_reg  <= a;
            b_reg  <= b;
            borrow <= 1'b0;
            count  <= '0;
            out    <= '0;
            state  <= SUB;
          end
        end
        SUB: begin
          out    <= {diff, out[WIDTH-1:1]};
          borrow <= borrow_nxt;
          a_reg  <= a_reg >> 1;
          b_reg  <= b_reg >> 1;
          count  <= count + CW'(1);
          if (count == LAST) begin
            state      <= DONE;
            borrow_out <= borrow_nxt;
`ifdef SUB_SERIAL_OVF_EN
            // On the last bit a_reg[0]/b_reg[0] are the captured operand MSBs.
            ovf        <= (a_reg[0] != b_reg[0]) && (diff != a_reg[0]);
`endif
          end
        end
        DONE: begin
          // Require en to drop before another start; a held en never restarts.
          if (!en) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_serial.sv
// Directed, table-driven bench for sub_serial (WIDTH=8); ovf checks only when SUB_SERIAL_OVF_EN is defined.
module tb_sub_serial;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] out;
  logic         borrow_out;
  logic         busy;
  logic         done;
`ifdef SUB_SERIAL_OVF_EN
  logic         ovf;
`endif

  sub_serial #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .a          (a),
    .b          (b),
    .out        (out),
    .borrow_out (borrow_out),
    .busy       (busy),
    .done       (done)
`ifdef SUB_SERIAL_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] dif;
    logic         brw;
    logic         ovf;
  } vec_t;

  vec_t vecs[8];
  int   tests;
  int   fails;
  logic last_borrow;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start one operation, check latency, result and hold behaviour.
  task automatic run_op(input vec_t v, input bit hold);
    int bc;
    @(negedge clk);
    a  = v.a;
    b  = v.b;
    en = 1'b1;
    @(negedge clk);
    if (!hold) en = 1'b0;
    a = ~v.a;
    b = v.a ^ 8'h5A;
    chk("start_clears_out", {24'd0, out}, 32'd0);
    chk("borrow_kept_at_start", {31'd0, borrow_out}, {31'd0, last_borrow});
    bc = 0;
    for (int i = 0; i < W; i++) begin
      if (busy && !done) bc++;
      @(negedge clk);
      a = a + 8'd37;
    end
    chk("busy_cycles", bc, W);
    chk("done_after_w_plus_1", {30'd0, busy, done}, 32'd1);
    chk("diff", {24'd0, out}, {24'd0, v.dif});
    chk("borrow", {31'd0, borrow_out}, {31'd0, v.brw});
`ifdef SUB_SERIAL_OVF_EN
    chk("ovf", {31'd0, ovf}, {31'd0, v.ovf});
`endif
    if (hold) begin
      bc = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (done && !busy && out == v.dif) bc++;
      end
      chk("hold_en_stays_done", bc, 5);
      en = 1'b0;
    end
    @(negedge clk);
    chk("back_to_idle", {30'd0, busy, done}, 32'd0);
    chk("out_holds_in_idle", {24'd0, out}, {24'd0, v.dif});
    last_borrow = v.brw;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    last_borrow = 1'b0;
    rst = 1'b0;
    en  = 1'b0;
    a   = '0;
    b   = '0;

    vecs[0] = '{8'd9,   8'd5,   8'h04, 1'b0, 1'b0};
    vecs[1] = '{8'd5,   8'd9,   8'hFC, 1'b1, 1'b0};
    vecs[2] = '{8'h00,  8'h01,  8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'hFF,  8'hFF,  8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h80,  8'h01,  8'h7F, 1'b0, 1'b1};
    vecs[5] = '{8'h7F,  8'hFF,  8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'd200, 8'd100, 8'h64, 1'b0, 1'b1};
    vecs[7] = '{8'h00,  8'h00,  8'h00, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset_out", {24'd0, out}, 32'd0);
    chk("reset_flags", {29'd0, borrow_out, busy, done}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_no_start", {30'd0, busy, done}, 32'd0);

    for (int i = 0; i < 8; i++) run_op(vecs[i], 1'b0);

    // en held high through the op and beyond must not restart.
    run_op(vecs[1], 1'b1);

    // Asynchronous reset mid-SUB; borrow_out is 1 from the previous op.
    @(negedge clk);
    a  = 8'd200;
    b  = 8'd100;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_op_busy", {30'd0, busy, done}, 32'd2);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_out", {24'd0, out}, 32'd0);
    chk("async_rst_flags", {29'd0, borrow_out, busy, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {30'd0, busy, done}, 32'd0);
    last_borrow = 1'b0;
    run_op(vecs[6], 1'b0);
    run_op(vecs[2], 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sub_serial.md
Name: sub_serial

Overview:
- Bit-serial subtractor; the inverse-operation partner of the team's bit-serial adder.
- Captures two WIDTH-bit operands and computes a − b one bit per clock, LSB first, using a ripple borrow register.
- Shifts the difference into a parallel result register and reports the final borrow.
- Sits beside add_serial in the datapath library. Used where area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits. Legal range is WIDTH ≥ 2.
- The count register width is $clog2(WIDTH), derived internally and not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; all state clears immediately while rst=0.
- en  input  1  start/hold request, level-sensitive.
- a  input  WIDTH  minuend, sampled only on the start edge.
- b  input  WIDTH  subtrahend, sampled only on the start edge.
- out  output  WIDTH  difference a−b mod 2^WIDTH, registered.
- borrow_out  output  1  final borrow (1 when a < b unsigned), registered.
- busy  output  1  high while the subtraction is in progress (state SUB).
- done  output  1  high while in state DONE.

Behaviour:
- Reset (rst=0):
  - state=IDLE; out, a_reg, b_reg, borrow, count and borrow_out all 0.
  - busy=0, done=0.
  - Reset asserted mid-operation aborts the subtraction; no partial result is retained.
- States: IDLE(0), SUB(1), DONE(2). Encoding 3 is illegal and returns to IDLE on the next edge with no register updates.
- IDLE:
  - en=0: stay in IDLE; all registers hold.
  - en=1: a_reg<=a, b_reg<=b, borrow<=0, count<=0, out<=0; go to SUB.
- SUB (one bit per cycle):
  - diff = a_reg[0]^b_reg[0]^borrow.
  - borrow <= (~a_reg[0]&b_reg[0]) | (~(a_reg[0]^b_reg[0])&borrow).
  - out <= {diff, out[WIDTH-1:1]}.
  - a_reg>>=1, b_reg>>=1, count<=count+1.
  - When count==WIDTH-1: go to DONE and load borrow_out with the borrow computed in that same cycle.
  - en is ignored in SUB. a and b may change freely after capture.
- DONE:
  - out and borrow_out hold.
  - en=1: stay in DONE. A new operation requires en to drop first; a held-high en never auto-restarts.
  - en=0: go to IDLE.
  - The result stays valid in IDLE until the next start edge clears out. borrow_out is not cleared by that start; it updates only on the next SUB→DONE transition.
- Outputs: busy = (state==SUB); done = (state==DONE). Both are decoded from the state register, so no combinational path from inputs.
- Latency:
  - en is sampled high at edge 0.
  - SUB occupies edges 1..WIDTH.
  - done rises after edge WIDTH (WIDTH+1 edges from the start request); for WIDTH=8, done is seen high after the 9th edge.
- Throughput: one operation per WIDTH+2 cycles minimum (IDLE capture, WIDTH SUB cycles, DONE).
- Arithmetic: unsigned, modulo 2^WIDTH. borrow_out=1 exactly when a<b. No saturation.

Optional Feature:
- Macro: SUB_SERIAL_OVF_EN.
- Defined:
  - Adds output ovf (1 bit), reset 0.
  - Loaded on the SUB→DONE transition with the two's-complement signed overflow: (a_msb != b_msb) && (diff_msb != a_msb), where a_msb and b_msb are captured at start.
  - ovf holds like borrow_out.
- Undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then start with a=8'd9, b=8'd5, en pulse 1 cycle -> busy high 8 cycles; done after 9th edge; out=8'h04, borrow_out=0.
- a=8'd5, b=8'd9 -> out=8'hFC, borrow_out=1. With SUB_SERIAL_OVF_EN, ovf=0.
- a=8'h00, b=8'h01 -> out=8'hFF, borrow_out=1. Then a=8'hFF, b=8'hFF -> out=8'h00, borrow_out=0.
- With SUB_SERIAL_OVF_EN: a=8'h80, b=8'h01 -> out=8'h7F, ovf=1, borrow_out=0. Then a=8'h7F, b=8'hFF -> out=8'h80, ovf=1, borrow_out=1.
- Hold en=1 through the whole operation and 5 extra cycles -> stays in DONE with done=1, no restart. Drop en -> IDLE next edge. Changing a/b during SUB does not alter the result.
- Start a=8'd200, b=8'd100; assert rst=0 asynchronously after the 4th SUB edge -> out, borrow_out, busy and done go to 0 immediately. After release, state is IDLE and a new operation computes correctly.
